blue_panel_ctl: RTL and testbench

//   Front panel command sequencer for the Blue SBC6120. It takes the debounced

---
 rtl/blue_panel_ctl.sv | 222 ++++++++++++++++++++++
 tb/tb_blue_panel_ctl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/blue_panel_ctl.sv
// blue_panel_ctl: front panel command sequencer for the Blue SBC6120.
// Turns debounced switch presses into single CPU panel commands over a
// valid/ack handshake and owns the panel address/EMA/data registers.
//
// Ports:
//   clock, reset            system clock, async active-high reset
//   fnsw[8:0], swreg[11:0]  debounced function switches / switch register
//   cpu_run                 CPU running (only HALT accepted while set)
//   cmd_valid/code/addr/data  command request to the CPU
//   cmd_ack, cmd_rdata      CPU acceptance and read data
//   addr_leds, ema_leds, data_leds  panel register displays
//   busy                    sequencer not idle
//
// Optional feature: define PANEL_AUTOREPEAT_EN to re-issue a held EXAM/DEP
// every REPEAT_TICKS clocks. The REPEAT_TICKS parameter only exists then.
module blue_panel_ctl
`ifdef PANEL_AUTOREPEAT_EN
  #(parameter int unsigned REPEAT_TICKS = 4_000_000)
`endif
(
  input  logic        clock,
  input  logic        reset,
  input  logic [8:0]  fnsw,
  input  logic [11:0] swreg,
  input  logic        cpu_run,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [14:0] cmd_addr,
  output logic [11:0] cmd_data,
  input  logic        cmd_ack,
  input  logic [11:0] cmd_rdata,
  output logic [11:0] addr_leds,
  output logic [2:0]  ema_leds,
  output logic [11:0] data_leds,
  output logic        busy
);

  localparam int unsigned FN_HALT  = 0;
  localparam int unsigned FN_CONT  = 1;
  localparam int unsigned FN_BOOT  = 2;
  localparam int unsigned FN_CLEAR = 3;
  localparam int unsigned FN_LA    = 4;
  localparam int unsigned FN_LXA   = 5;
  localparam int unsigned FN_EXAM  = 6;
  localparam int unsigned FN_DEP   = 7;
  localparam int unsigned FN_LOCK  = 8;

  localparam logic [2:0] C_HALT  = 3'd0;
  localparam logic [2:0] C_CONT  = 3'd1;
  localparam logic [2:0] C_BOOT  = 3'd2;
  localparam logic [2:0] C_CLEAR = 3'd3;
  localparam logic [2:0] C_READ  = 3'd4;
  localparam logic [2:0] C_WRITE = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_REL} state_t;

  state_t      state, state_n;
  logic [7:0]  fnsw_q;
  logic [7:0]  press, cand, allow;
  logic        cmd_valid_n;
  logic [2:0]  cmd_code_n;
  logic [14:0] cmd_addr_n;
  logic [11:0] cmd_data_n, addr_n, data_n;
  logic [2:0]  ema_n;
  logic        do_issue;
  logic [2:0]  issue_code;

`ifdef PANEL_AUTOREPEAT_EN
  localparam int unsigned CNT_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             rep, rep_n;
`endif

  // Rising-edge press detect; LOCK is a level, never a press.
  assign press = fnsw[7:0] & ~fnsw_q;

  // Next-state and register updates.
  always_comb begin
    state_n     = state;
    cmd_valid_n = cmd_valid;
    cmd_code_n  = cmd_code;
    cmd_addr_n  = cmd_addr;
    cmd_data_n  = cmd_data;
    addr_n      = addr_leds;
    ema_n       = ema_leds;
    data_n      = data_leds;
    do_issue    = 1'b0;
    issue_code  = cmd_code;
    allow       = '1;
`ifdef PANEL_AUTOREPEAT_EN
    cnt_n = cnt;
    rep_n = rep;
`endif
    if (fnsw[FN_LOCK] || cpu_run) begin
      allow          = '0;
      allow[FN_HALT] = 1'b1;
    end
    cand = press & allow;

    case (state)
      S_IDLE: begin
        if      (cand[FN_HALT])  begin do_issue = 1'b1; issue_code = C_HALT;  end
        else if (cand[FN_CLEAR]) begin do_issue = 1'b1; issue_code = C_CLEAR; end
        else if (cand[FN_BOOT])  begin do_issue = 1'b1; issue_code = C_BOOT;  end
        else if (cand[FN_CONT])  begin do_issue = 1'b1; issue_code = C_CONT;  end
        else if (cand[FN_LA]) begin
          addr_n  = swreg;
          state_n = S_WAIT_REL;
`ifdef PANEL_AUTOREPEAT_EN
          rep_n = 1'b0;
          cnt_n = '0;
`endif
        end
        else if (cand[FN_LXA]) begin
          // PDP-8 bits 9..11 are the three least significant bits.
          ema_n   = swreg[2:0];
          state_n = S_WAIT_REL;
`ifdef PANEL_AUTOREPEAT_EN
          rep_n = 1'b0;
          cnt_n = '0;
`endif
        end
        else if (cand[FN_EXAM])  begin do_issue = 1'b1; issue_code = C_READ;  end
        else if (cand[FN_DEP])   begin do_issue = 1'b1; issue_code = C_WRITE; end
      end

      S_ISSUE: begin
        if (cmd_ack) begin
          cmd_valid_n = 1'b0;
          state_n     = S_WAIT_REL;
          if (cmd_code == C_READ) begin
            data_n = cmd_rdata;
            addr_n = addr_leds + 12'd1;
          end else if (cmd_code == C_WRITE) begin
            data_n = cmd_data;
            addr_n = addr_leds + 12'd1;
          end
`ifdef PANEL_AUTOREPEAT_EN
          rep_n = (cmd_code == C_READ) || (cmd_code == C_WRITE);
          cnt_n = CNT_W'(REPEAT_TICKS - 1);
`endif
        end
      end

      S_WAIT_REL: begin
        if (fnsw[7:0] == 8'd0) begin
          state_n = S_IDLE;
`ifdef PANEL_AUTOREPEAT_EN
          rep_n = 1'b0;
          cnt_n = '0;
`endif
        end
`ifdef PANEL_AUTOREPEAT_EN
        // Held EXAM/DEP re-issues the same command once the counter expires.
        else if (rep && (((cmd_code == C_READ) && fnsw[FN_EXAM]) ||
                         ((cmd_code == C_WRITE) && fnsw[FN_DEP]))) begin
          if (cnt == '0) begin
            do_issue   = 1'b1;
            issue_code = cmd_code;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end else begin
          rep_n = 1'b0;
          cnt_n = '0;
        end
`endif
      end

      default: state_n = S_IDLE;
    endcase

    if (do_issue) begin
      cmd_valid_n = 1'b1;
      cmd_code_n  = issue_code;
      cmd_addr_n  = {ema_leds, addr_leds};
      cmd_data_n  = swreg;
      state_n     = S_ISSUE;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      fnsw_q    <= '1;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      addr_leds <= '0;
      ema_leds  <= '0;
      data_leds <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      fnsw_q    <= fnsw[7:0];
      cmd_valid <= cmd_valid_n;
      cmd_code  <= cmd_code_n;
      cmd_addr  <= cmd_addr_n;
      cmd_data  <= cmd_data_n;
      addr_leds <= addr_n;
      ema_leds  <= ema_n;
      data_leds <= data_n;
      busy      <= (state_n != S_IDLE);
    end
  end

`ifdef PANEL_AUTOREPEAT_EN
  // Autorepeat counter and "last command may repeat" flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      rep <= 1'b0;
    end else begin
      cnt <= cnt_n;
      rep <= rep_n;
    end
  end
`endif

endmodule

// File: tb/tb_blue_panel_ctl.sv
// Testbench for blue_panel_ctl: directed vector table, hand-written
// multi-cycle sequences, and randomized operations against a
// transaction-level panel model.
module tb_blue_panel_ctl;

  localparam int HALT = 0, CONT = 1, BOOT = 2, CLEAR = 3;
  localparam int LA = 4, LXA = 5, EXAM = 6, DEP = 7, LOCK = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  fnsw;
  logic [11:0] swreg;
  logic        cpu_run;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [14:0] cmd_addr;
  logic [11:0] cmd_data;
  logic        cmd_ack;
  logic [11:0] cmd_rdata;
  logic [11:0] addr_leds;
  logic [2:0]  ema_leds;
  logic [11:0] data_leds;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Panel model state
  logic [11:0] m_addr, m_data;
  logic [2:0]  m_ema;

  typedef struct {
    int          sw;
    logic [11:0] sreg;
    logic        run;
    logic        lock;
    logic [11:0] rdata;
    int          delay;
    logic        exp_cmd;
    logic        exp_busy;
    logic [2:0]  exp_code;
    logic [14:0] exp_caddr;
    logic [11:0] exp_cdata;
    logic [11:0] exp_dled;
    logic [11:0] exp_aled;
    logic [2:0]  exp_ema;
  } vec_t;

  vec_t vt[14];

  always #5 clock = ~clock;

`ifdef PANEL_AUTOREPEAT_EN
  blue_panel_ctl #(.REPEAT_TICKS(8)) dut (
    .clock(clock), .reset(reset), .fnsw(fnsw), .swreg(swreg),
    .cpu_run(cpu_run), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_ack(cmd_ack),
    .cmd_rdata(cmd_rdata), .addr_leds(addr_leds), .ema_leds(ema_leds),
    .data_leds(data_leds), .busy(busy)
  );
`else
  blue_panel_ctl dut (
    .clock(clock), .reset(reset), .fnsw(fnsw), .swreg(swreg),
    .cpu_run(cpu_run), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_ack(cmd_ack),
    .cmd_rdata(cmd_rdata), .addr_leds(addr_leds), .ema_leds(ema_leds),
    .data_leds(data_leds), .busy(busy)
  );
`endif

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int sw, logic [11:0] sreg, logic run, logic lock,
                              logic [11:0] rdata, int delay, logic ec, logic eb,
                              logic [2:0] code, logic [14:0] caddr, logic [11:0] cdata,
                              logic [11:0] dled, logic [11:0] aled, logic [2:0] ema);
    vec_t v;
    v.sw = sw; v.sreg = sreg; v.run = run; v.lock = lock; v.rdata = rdata;
    v.delay = delay; v.exp_cmd = ec; v.exp_busy = eb; v.exp_code = code;
    v.exp_caddr = caddr; v.exp_cdata = cdata; v.exp_dled = dled;
    v.exp_aled = aled; v.exp_ema = ema;
    return v;
  endfunction

  // Press one switch, run the handshake if a command comes out, release.
  task automatic apply(input vec_t v);
    fnsw = '0; fnsw[LOCK] = v.lock;
    cpu_run = v.run; swreg = v.sreg; cmd_rdata = v.rdata;
    tick();
    fnsw[v.sw] = 1'b1;
    tick();
    chk("valid_after_press", 32'(cmd_valid), 32'(v.exp_cmd));
    chk("busy_after_press", 32'(busy), 32'(v.exp_busy));
    if (v.exp_cmd) begin
      chk("cmd_code", 32'(cmd_code), 32'(v.exp_code));
      chk("cmd_addr", 32'(cmd_addr), 32'(v.exp_caddr));
      chk("cmd_data", 32'(cmd_data), 32'(v.exp_cdata));
      swreg = ~v.sreg;
      for (int i = 0; i < v.delay; i++) begin
        tick();
        chk("valid_hold", 32'(cmd_valid), 32'd1);
        chk("cmd_addr_hold", 32'(cmd_addr), 32'(v.exp_caddr));
        chk("cmd_data_hold", 32'(cmd_data), 32'(v.exp_cdata));
      end
      cmd_ack = 1'b1;
      tick();
      cmd_ack = 1'b0;
      chk("valid_drop", 32'(cmd_valid), 32'd0);
    end
    fnsw[v.sw] = 1'b0;
    tick(); tick();
    chk("busy_idle", 32'(busy), 32'd0);
    chk("valid_idle", 32'(cmd_valid), 32'd0);
    chk("data_leds", 32'(data_leds), 32'(v.exp_dled));
    chk("addr_leds", 32'(addr_leds), 32'(v.exp_aled));
    chk("ema_leds", 32'(ema_leds), 32'(v.exp_ema));
  endtask

  // Transaction-level model: derive the expected record for one operation.
  task automatic model_op(input int sw, input logic [11:0] sreg, input logic run,
                          input logic lock, input logic [11:0] rdata, input int delay,
                          output vec_t v);
    logic acc;
    v = mk(sw, sreg, run, lock, rdata, delay, 0, 0, 0, 0, 0, 0, 0, 0);
    acc = (lock || run) ? (sw == HALT) : 1'b1;
    if (acc) begin
      v.exp_busy = 1'b1;
      if (sw == LA) m_addr = sreg;
      else if (sw == LXA) m_ema = sreg[2:0];
      else begin
        v.exp_cmd   = 1'b1;
        v.exp_caddr = {m_ema, m_addr};
        v.exp_cdata = sreg;
        case (sw)
          HALT:  v.exp_code = 3'd0;
          CONT:  v.exp_code = 3'd1;
          BOOT:  v.exp_code = 3'd2;
          CLEAR: v.exp_code = 3'd3;
          EXAM:  begin v.exp_code = 3'd4; m_data = rdata; m_addr = m_addr + 1; end
          default: begin v.exp_code = 3'd5; m_data = sreg; m_addr = m_addr + 1; end
        endcase
      end
    end
    v.exp_dled = m_data; v.exp_aled = m_addr; v.exp_ema = m_ema;
  endtask

  initial begin
    int rises, last_t;
    vec_t v;
    reset = 1'b1; fnsw = '0; swreg = '0; cpu_run = 1'b0;
    cmd_ack = 1'b0; cmd_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_leds", 32'({addr_leds, ema_leds, data_leds}), 32'd0);
    chk("rst_cmd", 32'({cmd_code, cmd_addr, cmd_data}), 32'd0);

    //           sw     swreg    run lock rdata   dly cmd busy code caddr      cdata    dled     aled     ema
    vt[0]  = mk(LA,    12'o0200, 0, 0, 12'o0,    0, 0, 1, 0, 15'o0,     12'o0,    12'o0,    12'o0200, 0);
    vt[1]  = mk(EXAM,  12'o0000, 0, 0, 12'o7402, 5, 1, 1, 4, 15'o00200, 12'o0,    12'o7402, 12'o0201, 0);
    vt[2]  = mk(LA,    12'o7777, 0, 0, 12'o0,    0, 0, 1, 0, 15'o0,     12'o0,    12'o7402, 12'o7777, 0);
    vt[3]  = mk(LXA,   12'o0003, 0, 0, 12'o0,    0, 0, 1, 0, 15'o0,     12'o0,    12'o7402, 12'o7777, 3);
    vt[4]  = mk(DEP,   12'o1234, 0, 0, 12'o0,    0, 1, 1, 5, 15'o37777, 12'o1234, 12'o1234, 12'o0000, 3);
    vt[5]  = mk(EXAM,  12'o0000, 1, 0, 12'o0,    0, 0, 0, 0, 15'o0,     12'o0,    12'o1234, 12'o0000, 3);
    vt[6]  = mk(LA,    12'o0500, 1, 0, 12'o0,    0, 0, 0, 0, 15'o0,     12'o0,    12'o1234, 12'o0000, 3);
    vt[7]  = mk(EXAM,  12'o0000, 0, 1, 12'o0,    0, 0, 0, 0, 15'o0,     12'o0,    12'o1234, 12'o0000, 3);
    vt[8]  = mk(HALT,  12'o0000, 0, 1, 12'o0,    0, 1, 1, 0, 15'o30000, 12'o0,    12'o1234, 12'o0000, 3);
    vt[9]  = mk(CLEAR, 12'o0055, 0, 0, 12'o0,    2, 1, 1, 3, 15'o30000, 12'o0055, 12'o1234, 12'o0000, 3);
    vt[10] = mk(BOOT,  12'o0000, 0, 0, 12'o0,    0, 1, 1, 2, 15'o30000, 12'o0,    12'o1234, 12'o0000, 3);
    vt[11] = mk(CONT,  12'o0000, 0, 0, 12'o0,    1, 1, 1, 1, 15'o30000, 12'o0,    12'o1234, 12'o0000, 3);
    vt[12] = mk(HALT,  12'o0000, 1, 0, 12'o0,    0, 1, 1, 0, 15'o30000, 12'o0,    12'o1234, 12'o0000, 3);
    vt[13] = mk(DEP,   12'o4321, 0, 0, 12'o0,    3, 1, 1, 5, 15'o30000, 12'o4321, 12'o4321, 12'o0001, 3);
    foreach (vt[i]) apply(vt[i]);
    m_addr = 12'o0001; m_ema = 3'd3; m_data = 12'o4321;

    // Priority with CPU running: HALT wins, EXAM is dropped.
    cpu_run = 1'b1; fnsw = '0; tick();
    fnsw[HALT] = 1'b1; fnsw[EXAM] = 1'b1;
    tick();
    chk("prio_run_code", 32'(cmd_code), 32'd0);
    chk("prio_run_valid", 32'(cmd_valid), 32'd1);
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    fnsw = '0; tick();
    for (int i = 0; i < 4; i++) begin tick(); chk("prio_run_no_second", 32'(cmd_valid), 32'd0); end
    chk("prio_run_addr", 32'(addr_leds), 32'(m_addr));

    // Priority when halted: CLEAR > BOOT > EXAM.
    cpu_run = 1'b0; fnsw[CLEAR] = 1'b1; fnsw[BOOT] = 1'b1; fnsw[EXAM] = 1'b1;
    tick();
    chk("prio_halt_code", 32'(cmd_code), 32'd3);
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    fnsw = '0; tick(); tick();
    chk("prio_halt_idle", 32'(busy), 32'd0);

    // Second press during ISSUE is discarded; stray ack in IDLE is ignored.
    cmd_rdata = 12'o0707;
    fnsw[EXAM] = 1'b1; tick();
    fnsw[DEP] = 1'b1; tick(); tick();
    chk("issue_code_kept", 32'(cmd_code), 32'd4);
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    m_addr = m_addr + 1; m_data = 12'o0707;
    fnsw = '0; tick(); tick();
    for (int i = 0; i < 3; i++) begin tick(); chk("no_queued_cmd", 32'(cmd_valid), 32'd0); end
    cmd_ack = 1'b1; tick(); tick(); cmd_ack = 1'b0;
    chk("idle_ack_ignored", 32'({busy, data_leds, addr_leds}), 32'({1'b0, m_data, m_addr}));

    // Held EXAM: autorepeat every 8 clocks after ack, or exactly one READ.
    rises = 0; last_t = 0; cmd_rdata = 12'o1111;
    fnsw[EXAM] = 1'b1;
    for (int t = 0; t < 45; t++) begin
      tick();
      cmd_ack = 1'b0;
      if (cmd_valid) begin
        chk("rep_code", 32'(cmd_code), 32'd4);
        chk("rep_addr", 32'(cmd_addr), 32'({m_ema, m_addr}));
        if (rises > 0) chk("rep_period", 32'(t - last_t), 32'd9);
        m_addr = m_addr + 1; m_data = cmd_rdata;
        rises++; last_t = t; cmd_ack = 1'b1;
      end
    end
    cmd_ack = 1'b0;
`ifdef PANEL_AUTOREPEAT_EN
    chk("rep_count", 32'(rises), 32'd5);
`else
    chk("rep_count", 32'(rises), 32'd1);
`endif
    fnsw = '0; tick(); tick();
    chk("rep_release_addr", 32'(addr_leds), 32'(m_addr));
    chk("rep_release_busy", 32'(busy), 32'd0);

    // Reset mid-handshake drops valid at once; held EXAM is not a press.
    fnsw[EXAM] = 1'b1; tick();
    chk("pre_reset_valid", 32'(cmd_valid), 32'd1);
    reset = 1'b1; #1;
    chk("async_reset_valid", 32'(cmd_valid), 32'd0);
    tick(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); chk("held_thru_reset", 32'(cmd_valid), 32'd0); end
    chk("held_thru_reset_busy", 32'(busy), 32'd0);
    fnsw = '0; tick();
    fnsw[EXAM] = 1'b1; cmd_rdata = 12'o2222; tick();
    chk("repress_valid", 32'(cmd_valid), 32'd1);
    chk("repress_addr", 32'(cmd_addr), 32'd0);
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    fnsw = '0; tick(); tick();
    m_addr = 12'o0001; m_ema = 3'd0; m_data = 12'o2222;
    chk("repress_leds", 32'({addr_leds, data_leds}), 32'({m_addr, m_data}));

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      model_op(int'($urandom_range(0, 7)), 12'($urandom),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
               12'($urandom), int'($urandom_range(0, 3)), v);
      apply(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
